// File: rtl/mem_responder.sv
// Responder end of the pipeline memory request interface: one request at a time,
// fixed LATENCY from acceptance to a one-cycle done pulse, backed by resettable word storage.
module mem_responder #(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0]   idx_reg, idx_next;
    logic [15:0]             wdata_reg, wdata_next;
    logic                    op_wr_reg, op_wr_next;
    logic [15:0]             mem_reg [DEPTH];

    logic                    in_range, legal, illegal;
    logic                    commit, commit_wr;
    logic [DEPTH_LOG2-1:0]   commit_idx;
    logic [15:0]             commit_data;
    logic [15:0]             dout_next;
    logic                    err_next;

    always_comb begin
        in_range    = (addr >> (DEPTH_LOG2 + 1)) == 16'h0000;
        legal       = (rd ^ wr) && !addr[0] && in_range;
        illegal     = (rd || wr) && !legal;

        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        wdata_next  = wdata_reg;
        op_wr_next  = op_wr_reg;
        commit      = 1'b0;
        commit_wr   = op_wr_reg;
        commit_idx  = idx_reg;
        commit_data = wdata_reg;
        err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (legal) begin
                    idx_next   = addr[DEPTH_LOG2:1];
                    wdata_next = data_in;
                    op_wr_next = wr;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: the accepting edge is also the edge entering RESP.
                        state_next  = RESP;
                        commit      = 1'b1;
                        commit_wr   = wr;
                        commit_idx  = addr[DEPTH_LOG2:1];
                        commit_data = data_in;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 3'(LATENCY - 1);
                    end
                end else begin
                    err_next = illegal;
                end
            end
            WAIT: begin
                if (cnt_reg <= 3'd1) begin
                    state_next = RESP;
                    cnt_next   = 3'd0;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        dout_next = (commit && !commit_wr) ? mem_reg[commit_idx] : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            idx_reg   <= '0;
            wdata_reg <= 16'h0000;
            op_wr_reg <= 1'b0;
            data_out  <= 16'h0000;
            stall     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            wdata_reg <= wdata_next;
            op_wr_reg <= op_wr_next;
            data_out  <= dout_next;
            stall     <= (state_next == WAIT);
            done      <= (state_next == RESP);
            busy      <= (state_next != IDLE);
            err       <= err_next;
        end
    end

    // Storage must clear in a single reset edge, so it is built from resettable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= 16'h0000;
            end
        end else if (commit && commit_wr) begin
            mem_reg[commit_idx] <= commit_data;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Drives identical stimulus into a LATENCY=3 and a LATENCY=1 responder and checks both
// every cycle against a timeline-based reference model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst, rd, wr;
    logic [15:0] addr, data_in;

    logic [15:0] data_out [2];
    logic        stall [2], done [2], busy [2], err [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(3), .DEPTH_LOG2(8)) u_dut3 (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
        .data_out(data_out[0]), .stall(stall[0]), .done(done[0]), .busy(busy[0]), .err(err[0])
    );

    mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u_dut1 (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
        .data_out(data_out[1]), .stall(stall[1]), .done(done[1]), .busy(busy[1]), .err(err[1])
    );

    // Reference model: an accepted op at edge n0 is done after edge n0+lat-1,
    // stalls for the edges before that, and the edge n0+lat is the non-accepting RESP cycle.
    int          lat [2] = '{3, 1};
    logic [15:0] m_mem [2][256];
    bit          m_act [2];
    int          m_n0 [2];
    bit          m_wr [2];
    logic [7:0]  m_idx [2];
    logic [15:0] m_data [2];
    int          edge_n = 0;

    logic [15:0] e_dout [2];
    bit          e_stall [2], e_done [2], e_busy [2], e_err [2], e_chk_dout [2];

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit legal, illegal;
        for (int i = 0; i < 2; i++) begin
            e_dout[i] = 16'h0000; e_stall[i] = 0; e_done[i] = 0;
            e_busy[i] = 0; e_err[i] = 0; e_chk_dout[i] = 1;
            if (rst) begin
                for (int a = 0; a < 256; a++) m_mem[i][a] = 16'h0000;
                m_act[i] = 0;
            end else if (m_act[i] && edge_n < m_n0[i] + lat[i]) begin
                e_busy[i] = 1;
                if (edge_n == m_n0[i] + lat[i] - 1) e_done[i] = 1;
                else e_stall[i] = 1;
            end else if (m_act[i] && edge_n == m_n0[i] + lat[i]) begin
                m_act[i] = 0;
            end else begin
                m_act[i] = 0;
                legal   = (rd != wr) && (addr[0] == 1'b0) && (addr < 16'h0200);
                illegal = (rd || wr) && !legal;
                e_err[i] = illegal;
                if (legal) begin
                    m_act[i]  = 1;
                    m_n0[i]   = edge_n;
                    m_wr[i]   = wr;
                    m_idx[i]  = addr[8:1];
                    m_data[i] = data_in;
                    e_busy[i] = 1;
                    if (lat[i] == 1) e_done[i] = 1;
                    else e_stall[i] = 1;
                end
            end
            if (e_done[i]) begin
                if (m_wr[i]) begin
                    m_mem[i][m_idx[i]] = m_data[i];
                    e_chk_dout[i] = 0;
                end else begin
                    e_dout[i] = m_mem[i][m_idx[i]];
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit rdv, input bit wrv,
                         input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        rst = r; rd = rdv; wr = wrv; addr = a; data_in = d;
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            string p;
            p = (i == 0) ? "L3" : "L1";
            check_val({p, " stall"}, 16'(stall[i]), 16'(e_stall[i]));
            check_val({p, " done"},  16'(done[i]),  16'(e_done[i]));
            check_val({p, " busy"},  16'(busy[i]),  16'(e_busy[i]));
            check_val({p, " err"},   16'(err[i]),   16'(e_err[i]));
            if (e_chk_dout[i]) check_val({p, " data_out"}, data_out[i], e_dout[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 16'h0000, 16'h0000);
    endtask

    initial begin
        rst = 1; rd = 0; wr = 0; addr = 16'h0000; data_in = 16'h0000;
        cycle(1, 0, 0, 16'h0000, 16'h0000);
        cycle(1, 1, 0, 16'h0010, 16'h0000);
        idle(2);
        // write/readback
        cycle(0, 0, 1, 16'h0010, 16'hBEEF); idle(5);
        cycle(0, 1, 0, 16'h0010, 16'h0000); idle(5);
        // illegal requests
        cycle(0, 1, 1, 16'h0010, 16'h1111); idle(1);
        cycle(0, 0, 1, 16'h0011, 16'h2222); idle(1);
        cycle(0, 0, 1, 16'h0400, 16'h3333); idle(1);
        cycle(0, 1, 0, 16'h0010, 16'h0000); idle(5);
        // second write while busy is ignored
        cycle(0, 0, 1, 16'h0020, 16'h1234);
        cycle(0, 0, 1, 16'h0020, 16'h5678);
        idle(5);
        cycle(0, 1, 0, 16'h0020, 16'h0000); idle(5);
        // reset during WAIT discards the pending write
        cycle(0, 0, 1, 16'h0030, 16'hAAAA);
        cycle(1, 0, 0, 16'h0000, 16'h0000);
        idle(2);
        cycle(0, 1, 0, 16'h0030, 16'h0000); idle(5);
        cycle(0, 1, 0, 16'h0010, 16'h0000); idle(5);
        // continuous read
        for (int k = 0; k < 12; k++) cycle(0, 1, 0, 16'h0010, 16'h0000);
        idle(4);
        // randomized traffic over a small address set to provoke read-after-write
        for (int k = 0; k < 3000; k++) begin
            bit r, rdv, wrv;
            logic [15:0] a;
            int sel;
            r   = ($urandom_range(0, 99) == 0);
            sel = $urandom_range(0, 9);
            rdv = ($urandom_range(0, 2) == 0);
            wrv = ($urandom_range(0, 2) == 0);
            a   = 16'($urandom_range(0, 7) * 2);
            if (sel == 0) a = a | 16'h0001;
            else if (sel == 1) a = 16'($urandom_range(16'h0200, 16'hFFFF));
            else if (sel == 2) a = 16'h01FE;
            cycle(r, rdv, wrv, a, 16'($urandom));
        end
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: LATENCY, 3, cycles from request acceptance to done (legal 1..7).
REQ-002 Parameter: DEPTH_LOG2, 8, log2 of word count of the internal storage (256 words).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: addr  input  16  byte address of request.
REQ-006 Port: data_in  input  16  write data.
REQ-007 Port: rd  input  1  read request.
REQ-008 Port: wr  input  1  write request.
REQ-009 Port: data_out  output  16  read data, valid only while done=1.
REQ-010 Port: stall  output  1  request accepted, response pending.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: busy  output  1  responder not in IDLE.
REQ-013 Port: err  output  1  one-cycle illegal-request pulse.

Function
REQ-014 The block SHALL be the responder end of the pipeline's memory request interface; storage is 2^DEPTH_LOG2 16-bit words indexed by addr[DEPTH_LOG2:1].
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; all outputs SHALL be registered.
REQ-016 In IDLE, a request SHALL be accepted at edge E0 when exactly one of rd/wr is 1, addr[0]=0, and addr[15:DEPTH_LOG2+1]=0; addr, data_in, and the op type SHALL be captured at E0.
REQ-017 An illegal request in IDLE (rd=wr=1, addr[0]=1, or out-of-range address) SHALL produce err=1 for exactly the one cycle after the sampling edge, with no state change, no memory update, and no stall or done.
REQ-018 For LATENCY>=2: after E0, state SHALL be WAIT with stall=1 for LATENCY-1 cycles (3-bit down-counter), then RESP with done=1 and stall=0 for exactly one cycle, then IDLE.
REQ-019 For LATENCY=1: WAIT SHALL be skipped; done=1 in the cycle after E0.
REQ-020 A write SHALL update storage at the edge entering RESP; a read SHALL load data_out from storage at that same edge.
REQ-021 Read-after-write to the same address SHALL return the new data.
REQ-022 data_out SHALL be 0x0000 whenever done=0.
REQ-023 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-024 rd/wr/addr/data_in changes while busy=1 SHALL be ignored, with no err, no queuing, and no effect on the in-flight op.
REQ-025 A request present in the RESP cycle SHALL NOT be accepted; it is sampled again in IDLE. Back-to-back accepts are therefore separated by at least one IDLE cycle.
REQ-026 rd=wr=0 in IDLE SHALL produce no output activity.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, zero the counter, set data_out=0, stall=0, done=0, busy=0, err=0, and clear every storage word to 0x0000.
REQ-028 Reset mid-operation SHALL discard the pending op; a pending write SHALL NOT commit.
REQ-029 rst SHALL take priority over any simultaneous request.

Verification
REQ-030 LATENCY=3: wr=1, addr=0x0010, data_in=0xBEEF -> stall=1 for 2 cycles, done=1 in the 3rd cycle, busy low afterward.
REQ-031 Then rd=1, addr=0x0010 -> done in the 3rd cycle with data_out=0xBEEF; data_out=0x0000 in every other cycle.
REQ-032 rd=wr=1, or addr=0x0011, or addr=0x0400 -> err=1 for one cycle, stall=0, done=0, memory unchanged.
REQ-033 wr to 0x0020 (0x1234), then wr to 0x0020 (0x5678) asserted during WAIT -> only 0x1234 is stored; readback gives 0x1234.
REQ-034 wr to 0x0030 (0xAAAA), rst pulsed during WAIT -> all outputs 0 the next cycle; readback of 0x0030 gives 0x0000.
REQ-035 LATENCY=1: rd held high continuously -> done on alternating cycles, stall never asserted.
